node_input_arbiter: RTL
=======================

Name: node_input_arbiter

Overview:
Upstream stage of the ring node routing controller.
- Accepts 32-bit instruction words from three node inputs and buffers each in its own small FIFO:
  - ring port 0 (code 2'b00)
  - ring port 1 (code 2'b01)
  - local injection port (code 2'b10)
- Each cycle, arbitrates one buffered word into a registered output slot.
- The output slot drives the routing controller's source_port / instruction_in pair, with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, instruction word width; bits [31:29] = destination node, [28:26] = originating node.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, minimum 2.
- NODE_IP_BITWIDTH, 3, node address width (informational, carried to the package).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  3  per-port word valid; bit i = port code i.
- in_data  input  3*DATA_WIDTH  per-port words; port i occupies bits [i*32+31 : i*32].
- in_ready  output  3  per-port accept; bit i = FIFO i not full.
- out_valid  output  1  output slot holds a word.
- out_ready  input  1  downstream accepts the slot this cycle.
- source_port  output  2  code of the port the slot word came from (00/01/10).
- instruction_out  output  DATA_WIDTH  slot word, unmodified.

Behaviour:
Reset:
- On rst high, immediately (asynchronously): all FIFOs empty, in_ready = 3'b111, out_valid = 0, source_port = 2'b00, instruction_out = 0, round-robin pointer = port 0.
- Reset mid-operation discards all buffered and slot words.

Input handshake:
- Word i is accepted at an edge where in_valid[i] & in_ready[i].
- in_ready[i] = !full[i], registered state only; it does not look ahead to a same-cycle pop. A full FIFO therefore refuses a push even when popped that cycle.

FIFOs:
- Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
- full: addresses equal and MSBs differ. empty: pointers equal.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.

Slot load condition:
- load = (!out_valid | out_ready) & any FIFO non-empty.
- On load: the granted FIFO is popped, its word and code are written to the slot, and out_valid = 1.
- If !load and out_ready, out_valid -> 0.
- While out_valid & !out_ready, source_port and instruction_out stay bit-stable.

Arbitration (round-robin):
- Search order starts at (last_grant+1) mod 3 and wraps 2->0.
- The first non-empty FIFO wins; last_grant updates only on load.

Latency and throughput:
- A word accepted at edge E into an empty FIFO, with an empty or draining slot, appears on out_* after edge E+1. There is no bypass.
- Throughput is one word per cycle when out_ready is held high.

Other rules:
- Words from the same port leave in arrival order.
- No word is dropped or duplicated.

Optional Feature:
Macro RING_PRIORITY_EN.
- Defined: ring ports 0 and 1 round-robin between themselves. Local port 2 is granted only when FIFOs 0 and 1 are both empty. This prevents injection from starving in-flight ring traffic.
- Undefined: plain three-way round-robin as above.

Decomposition:
Package node_pkg:
- DATA_WIDTH, NODE_IP_BITWIDTH
- port codes PORT_RING0 = 2'b00, PORT_RING1 = 2'b01, PORT_LOCAL = 2'b10
- destination/origin field bit positions

Sub-module node_input_fifo:
- Parameterised by DATA_WIDTH and FIFO_DEPTH; instantiated three times.
- Ports: push/pop/din/dout/full/empty, same clk/rst.
- The arbiter and output slot stay in the top module.

Test Plan:
- Reset then idle: rst pulse mid-stream with 2 words buffered -> out_valid = 0, in_ready = 3'b111 immediately; nothing emitted after release.
- Single word: port 2 pushes 32'hA000_0000 at edge E, out_ready = 1 -> out_valid = 1, source_port = 2'b10, instruction_out = 32'hA000_0000 after edge E+1, and for exactly one cycle.
- Round-robin fairness: all three ports hold 3 words each, out_ready = 1 -> source_port sequence 00,01,10,00,01,10,00,01,10; per-port order preserved.
- Backpressure: out_ready = 0 for 6 cycles with port 0 pushing every cycle -> slot stable; in_ready[0] drops after 4 FIFO words + 1 slot word; no loss after release.
- Full boundary: FIFO 1 full, out_ready = 1 and in_valid[1] = 1 in the same cycle -> push refused that cycle, pop proceeds, in_ready[1] = 1 the next cycle.
- RING_PRIORITY_EN defined: ports 0 and 2 each hold 2 words -> sequence 00,00,10,10. Undefined -> 00,10,00,10.

Source files
------------

// File: rtl/node_input_arbiter_pkg.sv
// Shared definitions for the ring node input arbiter: word geometry,
// port codes and the round-robin search helper.
package node_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int NODE_IP_BITWIDTH = 3;
    localparam int FIFO_DEPTH       = 4;
    localparam int NUM_PORTS        = 3;

    // Port codes as presented on source_port.
    localparam logic [1:0] PORT_RING0 = 2'b00;
    localparam logic [1:0] PORT_RING1 = 2'b01;
    localparam logic [1:0] PORT_LOCAL = 2'b10;

    // Instruction word fields.
    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 29;
    localparam int ORIG_MSB = 28;
    localparam int ORIG_LSB = 26;

    typedef struct packed {
        logic       found;
        logic [1:0] port;
    } grant_t;

    // Successor of a port code in the 0 -> 1 -> 2 -> 0 cycle.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PORT_LOCAL) ? PORT_RING0 : p + 2'd1;
    endfunction

    // First requesting port, searching from start and wrapping 2 -> 0.
    function automatic grant_t rr_pick(input logic [2:0] req, input logic [1:0] start);
        grant_t     g;
        logic [1:0] p;
        g = '0;
        p = start;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!g.found && req[p]) begin
                g.found = 1'b1;
                g.port  = p;
            end
            p = next_port(p);
        end
        return g;
    endfunction

endpackage

// File: rtl/node_input_arbiter_if.sv
// Handshake bundle between the three node inputs, the arbiter and the
// routing controller. slave = arbiter side, master = the environment.
interface node_input_arbiter_if #(
    parameter int DATA_WIDTH = node_pkg::DATA_WIDTH
);
    logic [2:0]              in_valid;
    logic [3*DATA_WIDTH-1:0] in_data;
    logic [2:0]              in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              source_port;
    logic [DATA_WIDTH-1:0]   instruction_out;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, source_port, instruction_out
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, source_port, instruction_out
    );
endinterface

// File: rtl/node_input_fifo.sv
// Per-port input FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter. Push when full and
// pop when empty are ignored.
module node_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  wr_en, rd_en;

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;

    // Pointer advance on accepted push / pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignment so all flops sample pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty pointers make stale contents unreachable.
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/node_input_arbiter.sv
// Upstream stage of the ring node routing controller: three input FIFOs
// (ring 0, ring 1, local injection), a round-robin arbiter and one
// registered output slot with a valid/ready handshake.
// Optional build macro RING_PRIORITY_EN: ring ports share round-robin and
// the local port is served only when both ring FIFOs are empty.
module node_input_arbiter import node_pkg::*; #(
    parameter int DATA_WIDTH = node_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = node_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    node_input_arbiter_if.slave  bus
);
    logic [2:0]            fifo_full, fifo_empty, push, pop;
    logic [DATA_WIDTH-1:0] fifo_dout [NUM_PORTS];

    logic [2:0]            req, req_eff;
    grant_t                grant;
    logic                  load;

    logic                  out_valid_q, out_valid_d;
    logic [1:0]            source_q, source_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;   // first port examined next search

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        node_input_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   (bus.in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .dout_o  (fifo_dout[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    // Ready reflects registered fullness only; a same-cycle pop does not free a slot.
    assign bus.in_ready = ~fifo_full;
    assign push         = bus.in_valid & ~fifo_full;

    // Grant selection and slot load decision.
    always_comb begin
        req = ~fifo_empty;
`ifdef RING_PRIORITY_EN
        req_eff = (|req[1:0]) ? {1'b0, req[1:0]} : req;
`else
        req_eff = req;
`endif
        grant = rr_pick(req_eff, rr_ptr_q);
        load  = (!out_valid_q || bus.out_ready) && grant.found;
        pop   = load ? (3'b001 << grant.port) : 3'b000;
    end

    // Next slot contents and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        source_d    = source_q;
        data_d      = data_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            source_d    = grant.port;
            data_d      = fifo_dout[grant.port];
`ifdef RING_PRIORITY_EN
            // Local grants leave the ring alternation where it was.
            if (grant.port != PORT_LOCAL) rr_ptr_d = next_port(grant.port);
`else
            rr_ptr_d = next_port(grant.port);
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot and arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            source_q    <= PORT_RING0;
            data_q      <= '0;
            rr_ptr_q    <= PORT_RING0;
        end else begin
            out_valid_q <= out_valid_d;
            source_q    <= source_d;
            data_q      <= data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.source_port     = source_q;
    assign bus.instruction_out = data_q;

endmodule
